// File: rtl/cpu_pkg.sv
// Shared definitions for the byte-serial GCD processor.
// Holds the controller, UART receive and UART transmit state encodings
// together with the 8N1 frame constants used by cpu and uart_rx.
package cpu_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    WAIT_A,
    WAIT_B,
    COMPUTE,
    SEND
  } ctrl_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first.
// Ports:
//   clk      - system clock, all state on its rising edge
//   rst_n    - asynchronous active-low reset
//   rx_i     - raw serial input (synchronised here)
//   data_o   - last received byte
//   valid_o  - one-clock pulse when data_o holds a new byte
// Build option: CPU_FRAME_CHECK_EN drops bytes whose stop bit reads 0 and
// waits for the line to go high again before looking for a new start bit.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  // Synchroniser resets to the idle-high level; a line held low through
  // reset release is then seen as a start bit two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Start is level-detected; after the half-bit recheck the counter is
  // restarted so every later wrap lands in the middle of a bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef CPU_FRAME_CHECK_EN
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT_HIGH;
          end
`else
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = RX_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cpu.sv
// Board top of the byte-serial GCD processor.
// Receives operand A then operand B over the UART, reduces them by repeated
// subtraction, shows the result on the LEDs and sends it back over the UART.
// Ports:
//   sysclk   - system clock, all state on its rising edge
//   reset    - asynchronous active-low reset
//   led      - last GCD result
//   UART_TX  - 8N1 serial output, idle high
//   UART_RX  - 8N1 serial input
// Build option: CPU_FRAME_CHECK_EN (passed to uart_rx) rejects frames with a
// low stop bit.
module cpu
  import cpu_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  output logic [7:0] led,
  output logic       UART_TX,
  input  logic       UART_RX
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [7:0]    rx_data;
  logic          rx_valid;

  ctrl_state_e   state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    led_q, led_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (sysclk),
    .rst_n  (reset),
    .rx_i   (UART_RX),
    .data_o (rx_data),
    .valid_o(rx_valid)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      led_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      led_q      <= led_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Controller and GCD datapath. Received bytes are only taken in the two
  // WAIT states, so anything arriving during COMPUTE or SEND is dropped.
  // A|B covers all three terminal cases: equal operands or one of them zero.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    led_d   = led_q;
    case (state_q)
      WAIT_A: begin
        if (rx_valid) begin
          a_d     = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_valid) begin
          b_d     = rx_data;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if ((a_q == b_q) || (a_q == 8'd0) || (b_q == 8'd0)) begin
          led_d   = a_q | b_q;
          state_d = SEND;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      SEND: begin
        if ((tx_state_q == TX_STOP) && (tx_cnt_q == LAST_CNT)) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // Transmitter. It launches on the first clock spent in SEND, so the start
  // bit follows the LED update by one clock. The line is registered and the
  // value for the next bit is chosen together with the state change.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_line_d = 1'b1;
        if (state_q == SEND) begin
          tx_shift_d = led_q;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == LAST_CNT) begin
          tx_cnt_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == LAST_CNT) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == LAST_CNT) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign led     = led_q;
  assign UART_TX = tx_line_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the GCD processor. Runs the UART at 16 clocks per
// bit, drives directed and random operand pairs on UART_RX, decodes UART_TX
// frames in a monitor and compares LEDs and frames with a Euclid model.
module tb_cpu;

  localparam int BAUD     = 9600;
  localparam int CPB      = 16;
  localparam int CLK_FREQ = CPB * BAUD;

  logic       sysclk;
  logic       reset;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] led;

  int checks   = 0;
  int errors   = 0;
  int txStarts = 0;

  logic [7:0] txQueue[$];
  logic       stopQueue[$];

  cpu #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .led    (led),
    .UART_TX(UART_TX),
    .UART_RX(UART_RX)
  );

  // 10 ns system clock
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Euclid by remainder, deliberately unlike the subtract loop in the design
  function automatic logic [7:0] refGcd(input int x, input int y);
    int a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return 8'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame starting on the current negedge, then idle high
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int idleBits);
    UART_RX = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = data[i];
      repeat (CPB) @(negedge sysclk);
    end
    UART_RX = stopBit;
    repeat (CPB) @(negedge sysclk);
    UART_RX = 1'b1;
    repeat (idleBits * CPB) @(negedge sysclk);
  endtask

  // Wait (bounded) for a decoded TX frame, then compare LEDs and frame
  task automatic waitResult(input logic [7:0] expected, input string tag);
    int cyc;
    cyc = 0;
    while (txQueue.size() == 0 && cyc < 3000) begin
      @(negedge sysclk);
      cyc++;
    end
    checks++;
    assert (txQueue.size() > 0)
    else begin
      errors++;
      $error("[TB] FAIL %s_tx_timeout observed no frame expected 0x%02h", tag, expected);
    end
    if (txQueue.size() > 0) begin
      checkOutput({tag, "_led"}, led, expected);
      checkOutput({tag, "_txdata"}, txQueue.pop_front(), expected);
      checkOutput({tag, "_txstop"}, {7'd0, stopQueue.pop_front()}, 8'h01);
    end
    repeat (CPB) @(negedge sysclk);
  endtask

  task automatic runPair(input logic [7:0] a, input logic [7:0] b, input string tag);
    applyStimulus(a, 1'b1, 2);
    applyStimulus(b, 1'b1, 2);
    waitResult(refGcd(int'(a), int'(b)), tag);
  endtask

  // UART_TX decoder, sampling at mid-bit on negedges
  initial begin
    logic [7:0] rxByte;
    logic       stopVal;
    forever begin
      @(negedge sysclk);
      if (reset === 1'b1 && UART_TX === 1'b0) begin
        txStarts++;
        repeat (CPB / 2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sysclk);
          rxByte[i] = UART_TX;
        end
        repeat (CPB) @(negedge sysclk);
        stopVal = UART_TX;
        txQueue.push_back(rxByte);
        stopQueue.push_back(stopVal);
      end
    end
  end

  initial begin
    int startsBefore;
    int cyc;
    logic [7:0] ra, rb;

    UART_RX = 1'b1;
    reset   = 1'b0;
    repeat (5) @(negedge sysclk);
    checkOutput("reset_led", led, 8'h00);
    checkOutput("reset_tx", {7'd0, UART_TX}, 8'h01);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);

    $display("[TB] pair 0x35 0xF7");
    runPair(8'h35, 8'hF7, "gcd_35_f7");

    $display("[TB] reset pulse then pair 0x72 0x8A");
    reset = 1'b0;
    @(negedge sysclk);
    checkOutput("pulse_led", led, 8'h00);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
    runPair(8'h72, 8'h8A, "gcd_72_8a");

    $display("[TB] zero operand resolves immediately");
    applyStimulus(8'h00, 1'b1, 2);
    applyStimulus(8'h0C, 1'b1, 0);
    checkOutput("zero_fast_led", led, 8'h0C);
    waitResult(8'h0C, "gcd_00_0c");

    runPair(8'hC8, 8'hC8, "gcd_c8_c8");

    $display("[TB] reset in the middle of operand B");
    applyStimulus(8'h21, 1'b1, 2);
    UART_RX = 1'b0;
    repeat (4 * CPB) @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("midreset_led", led, 8'h00);
    checkOutput("midreset_tx", {7'd0, UART_TX}, 8'h01);
    UART_RX = 1'b1;
    reset   = 1'b1;
    startsBefore = txStarts;
    repeat (20 * CPB) @(negedge sysclk);
    checkOutput("midreset_no_tx", 8'(txStarts - startsBefore), 8'h00);
    checkOutput("midreset_led_hold", led, 8'h00);
    runPair(8'h0F, 8'h05, "gcd_0f_05");

    $display("[TB] frame with low stop bit");
    applyStimulus(8'h44, 1'b0, 2);
`ifdef CPU_FRAME_CHECK_EN
    applyStimulus(8'h12, 1'b1, 2);
    applyStimulus(8'h30, 1'b1, 2);
    waitResult(refGcd(32'h12, 32'h30), "framecheck");
`else
    applyStimulus(8'h12, 1'b1, 2);
    waitResult(refGcd(32'h44, 32'h12), "framecheck_off");
`endif

    $display("[TB] extra byte during SEND is dropped");
    applyStimulus(8'h24, 1'b1, 2);
    applyStimulus(8'h18, 1'b1, 0);
    cyc = 0;
    while (UART_TX !== 1'b0 && cyc < 3000) begin
      @(negedge sysclk);
      cyc++;
    end
    checkOutput("send_started", {7'd0, UART_TX}, 8'h00);
    applyStimulus(8'h99, 1'b1, 0);
    waitResult(refGcd(32'h24, 32'h18), "gcd_24_18");
    runPair(8'h1C, 8'h0E, "after_drop");

    $display("[TB] random pairs");
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 0) rb = 8'h00;
      if (i == 1) begin
        ra = 8'h01;
        rb = 8'hFF;
      end
      runPair(ra, rb, $sformatf("rand%0d_%02h_%02h", i, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
